// File: rtl/myproject_mul_pkg.sv
// Shared constants and narrowing helpers for the pipelined multiplier.
package myproject_mul_pkg;

  localparam int unsigned SAT_WRAP  = 0;
  localparam int unsigned SAT_CLAMP = 1;

  // Widest intermediate the narrowing helper operates on.
  localparam int unsigned NARROW_W  = 64;

  typedef struct packed {
    logic signed [NARROW_W-1:0] value;
    logic                       ovf;
  } sat_res_t;

  function automatic int unsigned prod_width(input int unsigned w0, input int unsigned w1);
    return w0 + w1;
  endfunction

  // Clamp value to the signed range of the given width and flag any clamping.
  function automatic sat_res_t sat_narrow(input logic signed [NARROW_W-1:0] value,
                                          input int unsigned width);
    sat_res_t                   res;
    logic signed [NARROW_W-1:0] hi;
    logic signed [NARROW_W-1:0] lo;
    res.value = value;
    res.ovf   = 1'b0;
    hi        = '0;
    lo        = '0;
    if (width > 0 && width < NARROW_W) begin
      hi = (64'sd1 <<< (width - 1)) - 64'sd1;
      lo = -hi - 64'sd1;
      if (value > hi) begin
        res.value = hi;
        res.ovf   = 1'b1;
      end else if (value < lo) begin
        res.value = lo;
        res.ovf   = 1'b1;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/myproject_mul_pipe_stage.sv
// One pipeline slice: a valid bit plus a data register, loaded when the stage may advance.
module myproject_mul_pipe_stage #(
  parameter int unsigned DW = 8
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_load,
  input  logic          i_valid,
  input  logic [DW-1:0] i_data,
  output logic          o_valid,
  output logic [DW-1:0] o_data
);

  logic          r_valid;
  logic [DW-1:0] r_data;

  // Data only captured for real items so bubbles do not disturb the held value.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (i_load) begin
      r_valid <= i_valid;
      if (i_valid) begin
        r_data <= i_data;
      end
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;

endmodule

// File: rtl/myproject_mul_pipe.sv
// Pipelined signed x (un)signed multiplier with valid/ready flow control, shift and narrowing.
module myproject_mul_pipe
  import myproject_mul_pkg::*;
#(
  parameter int unsigned DIN0_WIDTH  = 14,
  parameter int unsigned DIN1_WIDTH  = 9,
  parameter int unsigned DIN1_SIGNED = 0,
  parameter int unsigned DOUT_WIDTH  = 22,
  parameter int unsigned NUM_STAGE   = 3,
  parameter int unsigned SHIFT       = 0,
  parameter int unsigned SAT_MODE    = 0
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DIN0_WIDTH-1:0] din0,
  input  logic [DIN1_WIDTH-1:0] din1,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DOUT_WIDTH-1:0] dout,
  output logic                  ovf
);

  localparam int unsigned PW = prod_width(DIN0_WIDTH, DIN1_WIDTH);
  localparam int unsigned RW = DOUT_WIDTH + 1;
  localparam int unsigned MW = (NUM_STAGE > 1) ? NUM_STAGE - 1 : 1;

  logic                  r_en;
  logic [NUM_STAGE-1:0]  w_v;
  logic [NUM_STAGE-1:0]  w_adv;
  logic                  w_in_valid;
  logic signed [PW-1:0]  w_a;
  logic signed [PW-1:0]  w_b;
  logic signed [PW-1:0]  w_prod;
  logic [PW-1:0]         w_mid [MW];
  logic                  w_last_vin;
  logic [RW-1:0]         w_nar;
  logic [RW-1:0]         w_res;

  // Holds in_ready low until the first clock edge after reset release.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      r_en <= 1'b0;
    end else begin
      r_en <= 1'b1;
    end
  end

  // A stage may advance when empty or when everything downstream is moving.
  always_comb begin
    w_adv = '0;
    w_adv[NUM_STAGE-1] = !w_v[NUM_STAGE-1] || out_ready;
    for (int k = int'(NUM_STAGE) - 2; k >= 0; k--) begin
      w_adv[k] = !w_v[k] || w_adv[k+1];
    end
  end

  assign in_ready   = r_en && w_adv[0];
  assign w_in_valid = in_valid && r_en;

  assign w_a = PW'(signed'(din0));
  if (DIN1_SIGNED != 0) begin : g_b_signed
    assign w_b = PW'(signed'(din1));
  end else begin : g_b_unsigned
    assign w_b = signed'(PW'(din1));
  end

  // Full-width product cannot overflow PW bits for any operand pair.
  assign w_prod = w_a * w_b;

  function automatic logic [RW-1:0] narrow(input logic [PW-1:0] p);
    logic signed [PW-1:0]       s;
    logic signed [NARROW_W-1:0] se;
    sat_res_t                   r;
    s  = signed'(p) >>> SHIFT;
    se = NARROW_W'(s);
    r  = sat_narrow(se, DOUT_WIDTH);
    if (SAT_MODE == SAT_CLAMP) begin
      return {r.ovf, r.value[DOUT_WIDTH-1:0]};
    end
    return {r.ovf, se[DOUT_WIDTH-1:0]};
  endfunction

  for (genvar k = 0; k < NUM_STAGE - 1; k++) begin : g_mid
    logic          w_vin;
    logic [PW-1:0] w_din;
    if (k == 0) begin : g_first
      assign w_vin = w_in_valid;
      assign w_din = w_prod;
    end else begin : g_next
      assign w_vin = w_v[k-1];
      assign w_din = w_mid[k-1];
    end

    myproject_mul_pipe_stage #(
      .DW (PW)
    ) u_stage (
      .i_clk   (ap_clk),
      .i_rst_n (ap_rst_n),
      .i_load  (w_adv[k]),
      .i_valid (w_vin),
      .i_data  (w_din),
      .o_valid (w_v[k]),
      .o_data  (w_mid[k])
    );
  end

  if (NUM_STAGE == 1) begin : g_single
    assign w_last_vin = w_in_valid;
    assign w_nar      = narrow(w_prod);
    assign w_mid[0]   = '0;
  end else begin : g_multi
    assign w_last_vin = w_v[NUM_STAGE-2];
    assign w_nar      = narrow(w_mid[NUM_STAGE-2]);
  end

  myproject_mul_pipe_stage #(
    .DW (RW)
  ) u_stage_last (
    .i_clk   (ap_clk),
    .i_rst_n (ap_rst_n),
    .i_load  (w_adv[NUM_STAGE-1]),
    .i_valid (w_last_vin),
    .i_data  (w_nar),
    .o_valid (w_v[NUM_STAGE-1]),
    .o_data  (w_res)
  );

  assign out_valid   = w_v[NUM_STAGE-1];
  assign {ovf, dout} = w_res;

endmodule

// File: tb/tb_myproject_mul_pipe.sv
// Bench: three multiplier configurations share one stimulus stream and one scoreboard.
module tb_myproject_mul_pipe;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [13:0] din0 = '0;
  logic [8:0]  din1 = '0;

  logic [2:0]  ir;
  logic [2:0]  ov;
  logic [21:0] d0, d1, d2;
  logic        f0, f1, f2;
  logic [22:0] res [3];

  int n_chk = 0;
  int n_fail = 0;

  logic [68:0] sb [$];
  logic [21:0] got0 [$];
  logic [2:0]  prev_stall = '0;
  logic [22:0] prev_res [3];

  always #5 clk = ~clk;

  assign res[0] = {f0, d0};
  assign res[1] = {f1, d1};
  assign res[2] = {f2, d2};

  myproject_mul_pipe #(.SAT_MODE(0), .SHIFT(0)) u_wrap (
    .ap_clk(clk), .ap_rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[0]),
    .din0(din0), .din1(din1), .out_valid(ov[0]), .out_ready(out_ready),
    .dout(d0), .ovf(f0)
  );
  myproject_mul_pipe #(.SAT_MODE(1), .SHIFT(0)) u_sat (
    .ap_clk(clk), .ap_rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[1]),
    .din0(din0), .din1(din1), .out_valid(ov[1]), .out_ready(out_ready),
    .dout(d1), .ovf(f1)
  );
  myproject_mul_pipe #(.SAT_MODE(0), .SHIFT(4)) u_shf (
    .ap_clk(clk), .ap_rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[2]),
    .din0(din0), .din1(din1), .out_valid(ov[2]), .out_ready(out_ready),
    .dout(d2), .ovf(f2)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: exact product, floor shift, 22-bit signed range test, then wrap or clamp.
  function automatic logic [22:0] model(input int a, input int b, input int sh, input bit sat);
    longint p, s, hi, lo;
    logic [21:0] d;
    bit o;
    p  = longint'(a) * longint'(b);
    s  = p >>> sh;
    hi = (longint'(1) <<< 21) - 1;
    lo = -(longint'(1) <<< 21);
    o  = (s > hi) || (s < lo);
    if (sat && s > hi) s = hi;
    else if (sat && s < lo) s = lo;
    d = s[21:0];
    return {o, d};
  endfunction

  always @(negedge clk) begin
    int a, b;
    logic [68:0] e;
    if (!rst_n) begin
      sb.delete();
      prev_stall = '0;
      for (int d = 0; d < 3; d++) chk("reset_outputs", {ov[d], ir[d], res[d]}, 0);
    end else begin
      for (int d = 0; d < 3; d++) begin
        if (prev_stall[d]) chk("stall_hold", {ov[d], res[d]}, {1'b1, prev_res[d]});
      end
      for (int d = 1; d < 3; d++) chk("ctrl_match", {ir[d], ov[d]}, {ir[0], ov[0]});
      if (ov[0] && out_ready) begin
        if (sb.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_out: got %0h with no item outstanding", res[0]);
        end else begin
          e = sb.pop_front();
          for (int d = 0; d < 3; d++) chk("result", res[d], e[d*23 +: 23]);
          got0.push_back(res[0][21:0]);
        end
      end
      if (in_valid && ir[0]) begin
        a = int'($signed(din0));
        b = int'(din1);
        sb.push_back({model(a, b, 4, 0), model(a, b, 0, 1), model(a, b, 0, 0)});
      end
      for (int d = 0; d < 3; d++) begin
        prev_stall[d] = ov[d] && !out_ready;
        prev_res[d]   = res[d];
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic single(input logic [13:0] a, input logic [8:0] b, output int lat);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    din0      = a;
    din1      = b;
    lat       = 0;
    while (!ov[0] && lat < 10) begin
      step();
      lat++;
      if (lat == 1) in_valid = 1'b0;
    end
  endtask

  task automatic drain();
    int c;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    c = 0;
    while ((sb.size() != 0 || ov[0]) && c < 50) begin
      step();
      c++;
    end
    chk("drain_empty", {sb.size(), ov[0]}, 0);
  endtask

  function automatic logic [13:0] pick0();
    case ($urandom_range(0, 5))
      0: return 14'h2000;
      1: return 14'h1fff;
      default: return 14'($urandom);
    endcase
  endfunction

  function automatic logic [8:0] pick1();
    case ($urandom_range(0, 5))
      0: return 9'h1ff;
      1: return 9'h000;
      default: return 9'($urandom);
    endcase
  endfunction

  initial begin
    int lat, i, cyc, n_acc, n_spur;
    bit acc;

    chk("model_basic", model(100, 200, 0, 0), {1'b0, 22'd20000});
    chk("model_sat", model(-8192, 511, 0, 1), {1'b1, 22'h200000});
    chk("model_wrap", model(-8192, 511, 0, 0), {1'b1, 22'h002000});
    chk("model_shift_m1", model(-1, 1, 4, 0), {1'b0, 22'h3fffff});
    chk("model_shift_m17", model(-17, 1, 4, 0), {1'b0, 22'h3ffffe});

    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    step();
    chk("ready_after_reset", ir[0], 1);

    single(14'd100, 9'd200, lat);
    chk("basic_latency", lat, 3);
    chk("basic_wrap", res[0], {1'b0, 22'd20000});
    chk("basic_shift", res[2], {1'b0, 22'd1250});
    step();

    single(14'h2000, 9'h1ff, lat);
    chk("sat_result", res[1], {1'b1, 22'h200000});
    chk("wrap_result", res[0], {1'b1, 22'h002000});
    step();
    single(14'h3fff, 9'd1, lat);
    chk("shift_m1", res[2], {1'b0, 22'h3fffff});
    step();
    single(14'h3fef, 9'd1, lat);
    chk("shift_m17", res[2], {1'b0, 22'h3ffffe});
    drain();

    // Back-pressure: back-to-back inputs with out_ready toggling.
    got0.delete();
    i = 0;
    cyc = 0;
    while ((i < 10 || sb.size() != 0 || ov[0]) && cyc < 200) begin
      out_ready = (cyc % 2) == 0;
      if (i < 10) begin
        in_valid = 1'b1;
        din0 = 14'(i);
        din1 = 9'd3;
      end else begin
        in_valid = 1'b0;
      end
      #1;
      acc = in_valid && ir[0];
      step();
      if (acc) i++;
      cyc++;
    end
    in_valid = 1'b0;
    chk("bp_count", got0.size(), 10);
    for (int k = 0; k < 10 && k < got0.size(); k++) chk("bp_order", got0[k], 22'(k * 3));

    // Full pipeline: only NUM_STAGE items fit while the output is blocked.
    out_ready = 1'b0;
    in_valid = 1'b1;
    din0 = pick0();
    din1 = pick1();
    n_acc = 0;
    for (int c = 0; c < 8; c++) begin
      #1;
      acc = ir[0];
      step();
      if (acc) begin
        n_acc++;
        din0 = pick0();
        din1 = pick1();
      end
    end
    #1;
    chk("full_accept_count", n_acc, 3);
    chk("full_in_ready", ir[0], 0);
    in_valid = 1'b0;
    out_ready = 1'b1;
    #1;
    chk("full_release_ready", ir[0], 1);
    drain();

    // Random traffic with legal (held) input handshakes.
    acc = 1'b0;
    in_valid = 1'b0;
    for (int c = 0; c < 400; c++) begin
      out_ready = $urandom_range(0, 3) != 0;
      if (!in_valid || acc) begin
        in_valid = $urandom_range(0, 2) != 0;
        din0 = pick0();
        din1 = pick1();
      end
      #1;
      acc = in_valid && ir[0];
      step();
    end
    drain();

    // Reset while three items are in flight.
    out_ready = 1'b0;
    n_acc = 0;
    in_valid = 1'b1;
    cyc = 0;
    while (n_acc < 3 && cyc < 20) begin
      din0 = pick0();
      din1 = pick1();
      #1;
      acc = ir[0];
      step();
      if (acc) n_acc++;
      cyc++;
    end
    in_valid = 1'b0;
    chk("rst_pre_full", ov, 3'b111);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("rst_async_valid", ov, 0);
    chk("rst_async_dout", res[0], 0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    step();
    chk("rst_in_ready", ir[0], 1);
    out_ready = 1'b1;
    n_spur = 0;
    repeat (6) begin
      step();
      if (ov != 0) n_spur++;
    end
    chk("rst_no_stale", n_spur, 0);
    single(14'd5, 9'd7, lat);
    chk("rst_post_latency", lat, 3);
    chk("rst_post_result", res[0], {1'b0, 22'd35});
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    n_chk++;
    n_fail++;
    $display("FAIL global_timeout: simulation time %0t exceeded limit", $time);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
